collision_query: RTL
====================

Name: collision_query

Overview:
- Movement-legality checker; the reader-side client of the collision memory.
- Accepts a proposed character move (current top-left position plus direction) from the player-movement logic.
- Issues pipelined read addresses into the 320x240 collision RAM (1-cycle registered read latency) and returns allowed/blocked with the resulting position.
- Sits between keycode/movement control and the collision RAM read port; never writes the RAM.

Parameters:
- MAP_W, 320, map width in pixels; row stride of the collision RAM.
- MAP_H, 240, map height in pixels.
- SPR_W, 16, character bounding-box width.
- SPR_H, 16, character bounding-box height.
- STEP, 4, pixels moved per request.
- ADDR_W, 19, collision RAM address width.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  move request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_x  in  9  current top-left x, 0..MAP_W-SPR_W
- req_y  in  8  current top-left y, 0..MAP_H-SPR_H
- req_dir  in  2  0=UP 1=DOWN 2=LEFT 3=RIGHT
- col_read_address  out  ADDR_W  collision RAM read address
- col_data  in  4  collision RAM read data; bit0=1 means blocked, bits 3:1 ignored
- rsp_valid  out  1  one-cycle response strobe
- rsp_allowed  out  1  move legal
- rsp_x  out  9  resulting x (new if allowed, else req_x)
- rsp_y  out  8  resulting y

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: req_ready=1, col_read_address=0, rsp_valid=0, rsp_allowed=0, rsp_x=0, rsp_y=0. FSM goes to IDLE. Reset mid-operation abandons the request, with no rsp_valid.
- Handshake: accept on the rising edge where req_valid&&req_ready (cycle T). Register x, y and dir. req_ready=0 in every state except IDLE.
- FSM: IDLE -> CHECK -> SAMPLE0 -> SAMPLE1 -> SAMPLE2 -> DRAIN -> DONE -> IDLE.
- CHECK (T+1):
  - Compute target nx/ny (x±STEP or y±STEP).
  - Bounds fail: UP y<STEP; DOWN y+STEP+SPR_H>MAP_H; LEFT x<STEP; RIGHT x+STEP+SPR_W>MAP_W.
  - On fail, go straight to DONE: rsp_valid in cycle T+2, allowed=0, no RAM address issued.
  - Exact fit (e.g. nx=0, or nx+SPR_W=MAP_W) is in bounds.
- Sample points lie on the leading edge of the target box:
  - UP: row ny.
  - DOWN: row ny+SPR_H-1.
  - For UP/DOWN, columns nx, nx+SPR_W/2, nx+SPR_W-1.
  - LEFT: column nx.
  - RIGHT: column nx+SPR_W-1.
  - For LEFT/RIGHT, rows ny, ny+SPR_H/2, ny+SPR_H-1.
- Addressing:
  - address = y*MAP_W + x, computed by shift-add ((y<<8)+(y<<6)+x for 320); no multiplier.
  - Max 76799 fits 19 bits. Intermediate sums are zero-extended to ADDR_W.
- Pipelining:
  - Sample i address is driven in cycle T+2+i (i=0..2).
  - col_data for sample i is valid in cycle T+3+i and is OR-accumulated into a blocked flag (flag cleared in CHECK).
  - The DRAIN cycle (T+5) captures the last sample.
- DONE (T+6):
  - rsp_valid=1 for exactly one cycle.
  - rsp_allowed=!blocked.
  - rsp_x/rsp_y = target if allowed, else original.
  - rsp_allowed/rsp_x/rsp_y hold until the next DONE. col_read_address returns to 0.
- Back-to-back: IDLE is re-entered at T+7, so the next request is accepted at T+7 at the earliest. Throughput is one request per 7 cycles in bounds, 3 cycles out of bounds.
- req_x/req_y/req_dir changes after acceptance are ignored.

Decomposition:
- collision_pkg:
  - dir_t enum (UP/DOWN/LEFT/RIGHT)
  - state_t enum
  - MAP_W/MAP_H defaults
  - BLOCK_BIT=0
  - N_SAMPLES=3
- One sub-module, collision_addr_calc: combinational (x,y) -> ADDR_W address via shift-add; reusable by the renderer.

Test Plan:
- Reset asserted mid-idle and at T+3 of a request -> all outputs 0, req_ready=1 after release, no rsp_valid ever for the aborted request.
- RAM all zero; x=100 y=100 RIGHT accepted at T -> addresses 32119, 34679, 36919 in cycles T+2..T+4; rsp_valid at T+6 only, allowed=1, rsp_x=104, rsp_y=100.
- Same move with mem[34679]=4'b0001 -> allowed=0, rsp_x=100. Same move with mem[34679]=4'b1110 -> allowed=1 (upper bits ignored).
- Bounds:
  - x=2 LEFT -> rsp_valid at T+2, allowed=0, col_read_address stays 0.
  - x=4 LEFT -> allowed, rsp_x=0.
  - x=300 RIGHT -> allowed, rsp_x=304.
  - x=304 RIGHT -> blocked.
  - y=224 DOWN -> blocked (224+4+16=244>240).
  - y=220 DOWN -> allowed.
- UP at x=50 y=60 with mem[56*320+58]=1 -> blocked; addresses 17970, 17978, 17985.
- req_valid held high for 3 requests -> accepts at T, T+7, T+14; req_ready low in between; each rsp_valid is a single-cycle pulse.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and constants for the collision-map reader and its address helper.
package collision_pkg;

  localparam int MAP_W_DEF = 320;
  localparam int MAP_H_DEF = 240;
  localparam int BLOCK_BIT = 0;
  localparam int N_SAMPLES = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CHECK   = 3'd1;
  localparam state_t ST_SAMPLE0 = 3'd2;
  localparam state_t ST_SAMPLE1 = 3'd3;
  localparam state_t ST_SAMPLE2 = 3'd4;
  localparam state_t ST_DRAIN   = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/collision_addr_calc.sv
// Combinational pixel (x,y) to linear map address, y*MAP_W + x, built from shifted copies of y.
module collision_addr_calc #(
  parameter int MAP_W  = 320,
  parameter int ADDR_W = 19,
  parameter int X_W    = 9,
  parameter int Y_W    = 8
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAP_W);

  // Each set bit of the constant stride adds one shifted y (320 -> (y<<8) + (y<<6)).
  always_comb begin
    addr = ADDR_W'(x);
    for (int k = 0; k < ADDR_W; k++) begin
      if (STRIDE[k]) addr = addr + (ADDR_W'(y) << k);
    end
  end

endmodule

// File: rtl/collision_query.sv
// Movement-legality checker: bounds test, then three pipelined reads of the collision RAM
// along the leading edge of the target box, then a one-cycle allowed/blocked response.
module collision_query
  import collision_pkg::*;
#(
  parameter int MAP_W  = MAP_W_DEF,
  parameter int MAP_H  = MAP_H_DEF,
  parameter int SPR_W  = 16,
  parameter int SPR_H  = 16,
  parameter int STEP   = 4,
  parameter int ADDR_W = 19
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [8:0]        req_x,
  input  logic [7:0]        req_y,
  input  logic [1:0]        req_dir,
  output logic [ADDR_W-1:0] col_read_address,
  input  logic [3:0]        col_data,
  output logic              rsp_valid,
  output logic              rsp_allowed,
  output logic [8:0]        rsp_x,
  output logic [7:0]        rsp_y,
  output logic [2:0]        dbg_state
);

  // Handshake: a request is taken on the rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and rsp_valid is a single-cycle strobe with no backpressure.

  state_t      state_q, state_d;
  logic [8:0]  x_q, nx, sx;
  logic [7:0]  y_q, ny, sy;
  dir_t        dir_q;
  logic        blocked_q, blocked_now, oob, issue;
  logic [1:0]  idx;
  logic [ADDR_W-1:0] sample_addr;
  logic        col_data_unused;

  assign col_data_unused = ^col_data;
  assign req_ready       = (state_q == ST_IDLE);
  assign dbg_state       = state_q;
  assign blocked_now     = blocked_q | col_data[BLOCK_BIT];

  function automatic logic [8:0] span_off(input logic [1:0] i, input int span);
    case (i)
      2'd0:    span_off = 9'd0;
      2'd1:    span_off = 9'(span / 2);
      default: span_off = 9'(span - 1);
    endcase
  endfunction

  always_comb begin
    nx  = x_q;
    ny  = y_q;
    oob = 1'b0;
    case (dir_q)
      DIR_UP: begin
        ny  = y_q - 8'(STEP);
        oob = int'(y_q) < STEP;
      end
      DIR_DOWN: begin
        ny  = y_q + 8'(STEP);
        oob = int'(y_q) + STEP + SPR_H > MAP_H;
      end
      DIR_LEFT: begin
        nx  = x_q - 9'(STEP);
        oob = int'(x_q) < STEP;
      end
      default: begin
        nx  = x_q + 9'(STEP);
        oob = int'(x_q) + STEP + SPR_W > MAP_W;
      end
    endcase
  end

  // The address for sample i is prepared one state ahead so it is registered out on time.
  always_comb begin
    case (state_q)
      ST_SAMPLE0: idx = 2'd1;
      ST_SAMPLE1: idx = 2'd2;
      default:    idx = 2'd0;
    endcase
    if (dir_q == DIR_UP || dir_q == DIR_DOWN) begin
      sy = (dir_q == DIR_UP) ? ny : ny + 8'(SPR_H - 1);
      sx = nx + span_off(idx, SPR_W);
    end else begin
      sx = (dir_q == DIR_LEFT) ? nx : nx + 9'(SPR_W - 1);
      sy = ny + 8'(span_off(idx, SPR_H));
    end
    issue = (state_q == ST_CHECK && !oob) || state_q == ST_SAMPLE0 || state_q == ST_SAMPLE1;
  end

  collision_addr_calc #(
    .MAP_W  (MAP_W),
    .ADDR_W (ADDR_W),
    .X_W    (9),
    .Y_W    (8)
  ) u_addr (
    .x    (sx),
    .y    (sy),
    .addr (sample_addr)
  );

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:    state_d = req_valid ? ST_CHECK : ST_IDLE;
      ST_CHECK:   state_d = oob ? ST_DONE : ST_SAMPLE0;
      ST_SAMPLE0: state_d = ST_SAMPLE1;
      ST_SAMPLE1: state_d = ST_SAMPLE2;
      ST_SAMPLE2: state_d = ST_DRAIN;
      ST_DRAIN:   state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= ST_IDLE;
      x_q              <= '0;
      y_q              <= '0;
      dir_q            <= DIR_UP;
      blocked_q        <= 1'b0;
      col_read_address <= '0;
      rsp_valid        <= 1'b0;
      rsp_allowed      <= 1'b0;
      rsp_x            <= '0;
      rsp_y            <= '0;
    end else begin
      state_q          <= state_d;
      col_read_address <= issue ? sample_addr : '0;
      rsp_valid        <= 1'b0;
      if (state_q == ST_IDLE && req_valid) begin
        x_q   <= req_x;
        y_q   <= req_y;
        dir_q <= dir_t'(req_dir);
      end
      case (state_q)
        ST_CHECK: begin
          blocked_q <= 1'b0;
          if (oob) begin
            rsp_valid   <= 1'b1;
            rsp_allowed <= 1'b0;
            rsp_x       <= x_q;
            rsp_y       <= y_q;
          end
        end
        ST_SAMPLE1, ST_SAMPLE2: blocked_q <= blocked_now;
        // Last read data arrives here; the response goes out in DONE.
        ST_DRAIN: begin
          blocked_q   <= blocked_now;
          rsp_valid   <= 1'b1;
          rsp_allowed <= !blocked_now;
          rsp_x       <= blocked_now ? x_q : nx;
          rsp_y       <= blocked_now ? y_q : ny;
        end
        default: ;
      endcase
    end
  end

endmodule
